// File: rtl/cfg_uart.sv
// Config-link UART endpoint: 24-bit command frames in on RX_C, 16-bit responses out on TX_C, 8N1.
// Optional build macro CFG_RX_TIMEOUT_EN drops a partial RX frame after TIMEOUT_BITS idle bit times.
module cfg_uart #(
    parameter int BAUD_DIV     = 2604,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX_C,
    output logic        TX_C,
    output logic [23:0] cmd_data,
    output logic        frm_rdy,
    input  logic [15:0] tx_data,
    input  logic        strt_tx,
    output logic        tx_busy,
    output logic        tx_done
);

    // Handshake: strt_tx is taken on a clock edge where tx_busy=0 and tx_done=0; frm_rdy and
    // tx_done are single-cycle strobes with no backpressure.
    localparam int CW = ($clog2(BAUD_DIV) > 12) ? $clog2(BAUD_DIV) : 12;
    localparam logic [CW-1:0] BIT_END  = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_END = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    if (BAUD_DIV < 16 || TIMEOUT_BITS < 1) begin : g_param_check
        $error("cfg_uart: BAUD_DIV must be >= 16 and TIMEOUT_BITS >= 1");
    end

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

    // ---------------- receiver ----------------
    uart_state_t   rx_state_q, rx_state_d;
    logic          rx_s1, rx_s2, rx_s3;
    logic          rx_fall;
    logic [CW-1:0] rx_cnt_q;
    logic [2:0]    rx_bit_q;
    logic [7:0]    rx_shift_q;
    logic [1:0]    byte_cnt_q;
    logic [7:0]    slot0_q, slot1_q, slot2_q;
    logic          rx_tick, rx_shift_en, rx_stop_ok, rx_stop_err;
    logic          tmo_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_s3 <= 1'b1;
        end else begin
            rx_s1 <= RX_C;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
        end
    end

    assign rx_fall = rx_s3 & ~rx_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_state_q <= S_IDLE;
        else        rx_state_q <= rx_state_d;
    end

    always_comb begin
        rx_state_d = rx_state_q;
        case (rx_state_q)
            S_IDLE:  if (rx_fall) rx_state_d = S_START;
            S_START: if (rx_tick) rx_state_d = rx_s2 ? S_IDLE : S_DATA;
            S_DATA:  if (rx_tick && rx_bit_q == 3'd7) rx_state_d = S_STOP;
            S_STOP:  if (rx_tick) rx_state_d = S_IDLE;
            default: rx_state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rx_tick = 1'b0;
        case (rx_state_q)
            S_START:        rx_tick = (rx_cnt_q == HALF_END);
            S_DATA, S_STOP: rx_tick = (rx_cnt_q == BIT_END);
            default:        rx_tick = 1'b0;
        endcase
        rx_shift_en = (rx_state_q == S_DATA) && rx_tick;
        rx_stop_ok  = (rx_state_q == S_STOP) && rx_tick && rx_s2;
        rx_stop_err = (rx_state_q == S_STOP) && rx_tick && !rx_s2;
    end

    // byte_cnt_q==3 is a one-cycle marker: the frame is published on the edge after the stop sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            byte_cnt_q <= '0;
            slot0_q    <= '0;
            slot1_q    <= '0;
            slot2_q    <= '0;
            cmd_data   <= '0;
            frm_rdy    <= 1'b0;
        end else begin
            frm_rdy <= 1'b0;
            if (rx_state_q == S_IDLE || rx_tick) rx_cnt_q <= '0;
            else                                 rx_cnt_q <= rx_cnt_q + CNT_ONE;
            if (rx_state_q == S_START) rx_bit_q <= '0;
            else if (rx_shift_en)      rx_bit_q <= rx_bit_q + 3'd1;
            if (rx_shift_en) rx_shift_q <= {rx_s2, rx_shift_q[7:1]};
            if (byte_cnt_q == 2'd3) begin
                cmd_data   <= {slot0_q, slot1_q, slot2_q};
                frm_rdy    <= 1'b1;
                byte_cnt_q <= '0;
            end else if (rx_stop_ok) begin
                case (byte_cnt_q)
                    2'd0:    slot0_q <= rx_shift_q;
                    2'd1:    slot1_q <= rx_shift_q;
                    default: slot2_q <= rx_shift_q;
                endcase
                byte_cnt_q <= byte_cnt_q + 2'd1;
            end else if (rx_stop_err || tmo_hit) begin
                byte_cnt_q <= '0;
            end
        end
    end

`ifdef CFG_RX_TIMEOUT_EN
    localparam logic [15:0] TMO_LIM = 16'(TIMEOUT_BITS);
    logic [CW-1:0] tmo_cnt_q;
    logic [15:0]   tmo_bits_q;
    logic          tmo_run;

    assign tmo_run = (rx_state_q == S_IDLE) && (byte_cnt_q != 2'd0) && (byte_cnt_q != 2'd3);
    assign tmo_hit = tmo_run && (tmo_bits_q == TMO_LIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q  <= '0;
            tmo_bits_q <= '0;
        end else if (!tmo_run) begin
            tmo_cnt_q  <= '0;
            tmo_bits_q <= '0;
        end else if (!tmo_hit) begin
            if (tmo_cnt_q == BIT_END) begin
                tmo_cnt_q  <= '0;
                tmo_bits_q <= tmo_bits_q + 16'd1;
            end else begin
                tmo_cnt_q <= tmo_cnt_q + CNT_ONE;
            end
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // ---------------- transmitter ----------------
    uart_state_t   tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q;
    logic [2:0]    tx_bit_q;
    logic [7:0]    tx_shift_q;
    logic [7:0]    tx_lo_q;
    logic          tx_hi_q;
    logic          tx_accept, tx_bit_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tx_state_q <= S_IDLE;
        else        tx_state_q <= tx_state_d;
    end

    always_comb begin
        tx_state_d = tx_state_q;
        case (tx_state_q)
            S_IDLE:  if (tx_accept) tx_state_d = S_START;
            S_START: if (tx_bit_end) tx_state_d = S_DATA;
            S_DATA:  if (tx_bit_end && tx_bit_q == 3'd7) tx_state_d = S_STOP;
            S_STOP:  if (tx_bit_end) tx_state_d = tx_hi_q ? S_START : S_IDLE;
            default: tx_state_d = S_IDLE;
        endcase
    end

    always_comb begin
        tx_accept  = (tx_state_q == S_IDLE) && strt_tx && !tx_busy && !tx_done;
        tx_bit_end = (tx_state_q != S_IDLE) && (tx_cnt_q == BIT_END);
    end

    // TX_C is registered and changes on the same edge as the state, so each bit lasts BAUD_DIV cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_lo_q    <= '0;
            tx_hi_q    <= 1'b0;
            TX_C       <= 1'b1;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (tx_state_q == S_IDLE || tx_bit_end) tx_cnt_q <= '0;
            else                                    tx_cnt_q <= tx_cnt_q + CNT_ONE;
            if (tx_accept) begin
                tx_shift_q <= tx_data[15:8];
                tx_lo_q    <= tx_data[7:0];
                tx_hi_q    <= 1'b1;
                TX_C       <= 1'b0;
                tx_busy    <= 1'b1;
            end else if (tx_bit_end) begin
                case (tx_state_q)
                    S_START: begin
                        TX_C       <= tx_shift_q[0];
                        tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                        tx_bit_q   <= '0;
                    end
                    S_DATA: begin
                        TX_C       <= (tx_bit_q == 3'd7) ? 1'b1 : tx_shift_q[0];
                        tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                        tx_bit_q   <= tx_bit_q + 3'd1;
                    end
                    S_STOP: begin
                        if (tx_hi_q) begin
                            tx_shift_q <= tx_lo_q;
                            tx_hi_q    <= 1'b0;
                            TX_C       <= 1'b0;
                        end else begin
                            tx_done <= 1'b1;
                            tx_busy <= 1'b0;
                        end
                    end
                    default: TX_C <= 1'b1;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cfg_uart.sv
// Bench for cfg_uart at BAUD_DIV=16: RX frames and TX words are checked through expected queues
// by independent monitors; timing and reset behaviour are checked directly.
module tb_cfg_uart;

    localparam int BD = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        RX_C;
    logic        TX_C;
    logic [23:0] cmd_data;
    logic        frm_rdy;
    logic [15:0] tx_data;
    logic        strt_tx;
    logic        tx_busy;
    logic        tx_done;

    logic [23:0] rx_q[$];
    logic [15:0] tx_q[$];
    int n_cmp  = 0;
    int n_fail = 0;

    cfg_uart #(.BAUD_DIV(BD), .TIMEOUT_BITS(20)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .RX_C     (RX_C),
        .TX_C     (TX_C),
        .cmd_data (cmd_data),
        .frm_rdy  (frm_rdy),
        .tx_data  (tx_data),
        .strt_tx  (strt_tx),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic v);
        RX_C = v;
        repeat (BD) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_bit);
        RX_C = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        send_byte(b0, 1'b1);
        send_byte(b1, 1'b1);
        send_byte(b2, 1'b1);
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!tx_done && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic tx_test();
        int cyc;
        @(negedge clk);
        tx_data = 16'h0A5A;
        strt_tx = 1'b1;
        tx_q.push_back(16'h0A5A);
        @(posedge clk); #1;
        strt_tx = 1'b0;
        tx_data = 16'hFFFF;
        check("busy_after_accept", {31'd0, tx_busy}, 32'd1);
        cyc = 0;
        while (!tx_done && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 100)      strt_tx = 1'b1;
            else if (cyc == 101) strt_tx = 1'b0;
        end
        check("tx_done_latency", cyc, 32'd320);
        check("busy_low_at_done", {31'd0, tx_busy}, 32'd0);
        tx_data = 16'hC3F0;
        strt_tx = 1'b1;
        @(posedge clk); #1;
        check("strt_with_done_ignored", {31'd0, tx_busy}, 32'd0);
        tx_q.push_back(16'hC3F0);
        @(posedge clk); #1;
        strt_tx = 1'b0;
        check("strt_after_done_taken", {31'd0, tx_busy}, 32'd1);
        wait_done(cyc);
        check("tx_done_latency_2", cyc, 32'd320);
    endtask

    // ---------------- scoreboard monitors ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && frm_rdy === 1'b1) begin
                if (rx_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_frm_rdy: got cmd_data %h, required no frame", cmd_data);
                end else begin
                    check("cmd_data", {8'd0, cmd_data}, {8'd0, rx_q.pop_front()});
                end
            end
        end
    end

    // Samples TX_C mid-bit for 20 contiguous bit times from the first start bit.
    initial begin
        logic        act;
        int          cnt;
        int          nb;
        logic [19:0] bits;
        logic [15:0] word;
        act = 1'b0; cnt = 0; nb = 0; bits = '0;
        forever begin
            @(negedge clk or negedge rst_n);
            if (rst_n !== 1'b1) begin
                act = 1'b0;
            end else if (!act) begin
                if (TX_C === 1'b0) begin
                    act = 1'b1; cnt = 0; nb = 0;
                end
            end else begin
                cnt++;
                if (cnt % BD == BD / 2) begin
                    bits[nb] = TX_C;
                    nb++;
                    if (nb == 20) begin
                        act  = 1'b0;
                        word = {bits[8:1], bits[18:11]};
                        check("tx_framing", {28'd0, bits[0], bits[9], bits[10], bits[19]}, 32'h5);
                        if (tx_q.size() == 0) begin
                            n_cmp++;
                            n_fail++;
                            $display("FAIL unexpected_tx_word: got %h, required no transmission", word);
                        end else begin
                            check("tx_word", {16'd0, word}, {16'd0, tx_q.pop_front()});
                        end
                    end
                end
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        RX_C = 1'b1; strt_tx = 1'b0; tx_data = '0; rst_n = 1'b1;
        #2 rst_n = 1'b0;
        idle(3);
        check("rst_TX_C", {31'd0, TX_C}, 32'd1);
        check("rst_cmd_data", {8'd0, cmd_data}, 32'd0);
        check("rst_frm_rdy", {31'd0, frm_rdy}, 32'd0);
        check("rst_tx_busy", {31'd0, tx_busy}, 32'd0);
        check("rst_tx_done", {31'd0, tx_done}, 32'd0);
        rst_n = 1'b1;
        idle(5);

        // basic frame, then stability
        rx_q.push_back(24'h800123);
        send_frame(8'h80, 8'h01, 8'h23);
        idle(20);
        check("t1_frame_seen", rx_q.size(), 32'd0);
        idle(100);
        check("t1_cmd_stable", {8'd0, cmd_data}, 32'h800123);

        // TX with mid-frame and on-done requests, RX frame running concurrently
        fork
            tx_test();
            begin
                idle(40);
                rx_q.push_back(24'h6C3B9D);
                send_frame(8'h6C, 8'h3B, 8'h9D);
            end
        join
        idle(40);
        check("t2_frame_seen", rx_q.size(), 32'd0);
        check("t2_tx_seen", tx_q.size(), 32'd0);

        // start-bit glitch
        RX_C = 1'b0;
        idle(4);
        RX_C = 1'b1;
        idle(40);
        rx_q.push_back(24'hA55A00);
        send_frame(8'hA5, 8'h5A, 8'h00);
        idle(20);
        check("t3_frame_seen", rx_q.size(), 32'd0);

        // framing error on byte 2
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b0);
        idle(40);
        check("t4_cmd_unchanged", {8'd0, cmd_data}, 32'hA55A00);
        rx_q.push_back(24'h40007F);
        send_frame(8'h40, 8'h00, 8'h7F);
        idle(20);
        check("t4_frame_seen", rx_q.size(), 32'd0);

        // reset in the middle of TX and RX
        tx_data = 16'h1234;
        strt_tx = 1'b1;
        idle(1);
        strt_tx = 1'b0;
        fork
            send_byte(8'h99, 1'b1);
            begin
                idle(60);
                rst_n = 1'b0;
                #1;
                check("t5_rst_TX_C", {31'd0, TX_C}, 32'd1);
                check("t5_rst_cmd_data", {8'd0, cmd_data}, 32'd0);
                check("t5_rst_tx_busy", {31'd0, tx_busy}, 32'd0);
                check("t5_rst_frm_rdy", {31'd0, frm_rdy}, 32'd0);
            end
        join
        idle(5);
        rst_n = 1'b1;
        idle(20);
        check("t5_TX_C_idle", {31'd0, TX_C}, 32'd1);
        rx_q.push_back(24'h5EC001);
        send_frame(8'h5E, 8'hC0, 8'h01);
        idle(20);
        check("t5_frame_seen", rx_q.size(), 32'd0);

        // stale partial frame followed by a long gap
        send_byte(8'hB0, 1'b1);
        send_byte(8'hB1, 1'b1);
        idle(25 * BD);
`ifdef CFG_RX_TIMEOUT_EN
        rx_q.push_back(24'h112233);
`else
        rx_q.push_back(24'hB0B111);
`endif
        send_frame(8'h11, 8'h22, 8'h33);
        idle(20);
        check("t6_frame_seen", rx_q.size(), 32'd0);
        check("t6_tx_quiet", tx_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
